// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - instruction fetch stage: PC, ROM addressing, in-order {pc, instr} queue, redirect flush
//
// Ports:
//   clk            system clock, all state updates on the rising edge
//   rst            synchronous reset, active-high, highest priority
//   imem_addr      ROM word address, driven straight from the pc register
//   imem_rdata     combinational ROM read data for imem_addr
//   redirect_valid flush the queue and load redirect_pc this cycle
//   redirect_pc    redirect target word address
//   out_valid      queue head holds an instruction and no redirect is active
//   out_ready      decode accepts the head this cycle
//   out_instr      instruction at the queue head, 0 when empty
//   out_pc         word address of out_instr, 0 when empty
//   occupancy      number of valid queue entries

module instr_fetch_unit #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic [31:0]                imem_addr,
  input  logic [31:0]                imem_rdata,
  input  logic                       redirect_valid,
  input  logic [31:0]                redirect_pc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_instr,
  output logic [31:0]                out_pc,
  output logic [$clog2(DEPTH):0]     occupancy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]   pc;
  logic [31:0]   q_pc    [DEPTH];
  logic [31:0]   q_instr [DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [CW-1:0] count;

  logic          not_empty;
  logic          not_full;
  logic          pop;
  logic          fetch;

  assign imem_addr = pc;
  assign not_empty = (count != '0);
  assign not_full  = (count < CW'(DEPTH));

  // A redirect hides the head so decode never consumes a stale instruction
  // in the same cycle the queue is being flushed.
  assign out_valid = not_empty && !redirect_valid;
  assign pop       = out_valid && out_ready;

  // When full, a pop frees the head slot at the same edge, so the new word
  // can go into the tail slot (which is the slot being freed).
  assign fetch     = !redirect_valid && (not_full || pop);

  // Outputs come only from queue registers; imem_rdata never reaches them
  // combinationally.
  assign out_instr = not_empty ? q_instr[head] : '0;
  assign out_pc    = not_empty ? q_pc[head]    : '0;
  assign occupancy = count;

  // Queue storage needs no reset: entries are only visible while counted.
  always_ff @(posedge clk) begin
    if (!rst && fetch) begin
      q_pc[tail]    <= pc;
      q_instr[tail] <= imem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc    <= RESET_PC;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (redirect_valid) begin
      pc    <= redirect_pc;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (fetch) begin
        tail <= tail + AW'(1);
        pc   <= pc + 32'd1;
      end
      if (pop) begin
        head <= head + AW'(1);
      end
      case ({fetch, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - self-checking bench for instr_fetch_unit

module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [2:0]  occupancy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // ROM model: word k holds A000_0000 + k
  assign imem_rdata = 32'hA000_0000 + imem_addr;

  instr_fetch_unit #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .occupancy      (occupancy)
  );

  typedef struct {
    logic        rst;
    logic        rv;
    logic [31:0] rp;
    logic        rdy;
    logic        e_valid;
    logic [31:0] e_instr;
    logic [31:0] e_pc;
    logic [2:0]  e_occ;
    logic [31:0] e_addr;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic rv, input logic [31:0] rp, input logic rdy,
                     input logic ev, input logic [31:0] ei, input logic [31:0] ep,
                     input logic [2:0] eo, input logic [31:0] ea);
    vec_t v;
    v.rst = r; v.rv = rv; v.rp = rp; v.rdy = rdy;
    v.e_valid = ev; v.e_instr = ei; v.e_pc = ep; v.e_occ = eo; v.e_addr = ea;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic rv, input logic [31:0] rp, input logic rdy);
    rst = r; redirect_valid = rv; redirect_pc = rp; out_ready = rdy;
  endtask

  // advance to the next falling edge, passing one rising edge
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_all(input string tag, input logic ev, input logic [31:0] ei,
                         input logic [31:0] ep, input logic [2:0] eo, input logic [31:0] ea);
    chk({tag, ".valid"}, {31'd0, out_valid}, {31'd0, ev});
    chk({tag, ".instr"}, out_instr, ei);
    chk({tag, ".pc"},    out_pc, ep);
    chk({tag, ".occ"},   {29'd0, occupancy}, {29'd0, eo});
    chk({tag, ".addr"},  imem_addr, ea);
  endtask

  localparam logic [31:0] A = 32'hA000_0000;

  initial begin
    // test 1: stream with out_ready high from release
    add(0,0,0,1, 0, 0,     0, 0, 0);
    add(0,0,0,1, 1, A+0,   0, 1, 1);
    add(0,0,0,1, 1, A+1,   1, 1, 2);
    add(0,0,0,1, 1, A+2,   2, 1, 3);
    // test 2: backpressure then release
    add(1,0,0,0, 1, A+3,   3, 1, 4);
    add(0,0,0,0, 0, 0,     0, 0, 0);
    add(0,0,0,0, 1, A+0,   0, 1, 1);
    add(0,0,0,0, 1, A+0,   0, 2, 2);
    add(0,0,0,0, 1, A+0,   0, 3, 3);
    add(0,0,0,0, 1, A+0,   0, 4, 4);
    add(0,0,0,0, 1, A+0,   0, 4, 4);
    add(0,0,0,1, 1, A+0,   0, 4, 4);
    add(0,0,0,1, 1, A+1,   1, 4, 5);
    add(0,0,0,1, 1, A+2,   2, 4, 6);
    add(0,0,0,1, 1, A+3,   3, 4, 7);
    add(0,0,0,1, 1, A+4,   4, 4, 8);
    // test 3: redirect while full
    add(1,0,0,0, 1, A+5,   5, 4, 9);
    add(0,0,0,0, 0, 0,     0, 0, 0);
    add(0,0,0,0, 1, A+0,   0, 1, 1);
    add(0,0,0,0, 1, A+0,   0, 2, 2);
    add(0,0,0,0, 1, A+0,   0, 3, 3);
    add(0,0,0,0, 1, A+0,   0, 4, 4);
    add(0,1,32'h40,1, 0, A+0, 0, 4, 4);
    add(0,0,0,1, 0, 0,     0, 0, 32'h40);
    add(0,0,0,1, 1, A+32'h40, 32'h40, 1, 32'h41);
    add(0,0,0,1, 1, A+32'h41, 32'h41, 1, 32'h42);

    drive(1, 0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].rv, vecs[i].rp, vecs[i].rdy);
      #1;
      chk_all($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_instr,
              vecs[i].e_pc, vecs[i].e_occ, vecs[i].e_addr);
      step();
    end

    // test 4: redirect coinciding with out_ready at count=2, then held redirect
    drive(0, 0, 0, 0);
    step();
    drive(0, 1, 32'd10, 1);
    #1;
    chk("t4.valid_during_redirect", {31'd0, out_valid}, 32'd0);
    chk("t4.occ_before_flush", {29'd0, occupancy}, 32'd2);
    step();
    drive(0, 1, 32'd20, 1);
    #1;
    chk("t4.occ_flushed", {29'd0, occupancy}, 32'd0);
    chk("t4.addr10", imem_addr, 32'd10);
    step();
    drive(0, 1, 32'd30, 1);
    #1;
    chk("t4.addr20", imem_addr, 32'd20);
    step();
    drive(0, 0, 0, 1);
    #1;
    chk_all("t4.after", 0, 0, 0, 0, 32'd30);
    step();
    #1;
    chk_all("t4.first", 1, A + 32'd30, 32'd30, 1, 32'd31);
    step();
    #1;
    chk_all("t4.second", 1, A + 32'd31, 32'd31, 1, 32'd32);

    // test 5: pc wrap and pointer wrap
    drive(0, 1, 32'hFFFF_FFFE, 1);
    step();
    drive(0, 0, 0, 1);
    #1;
    chk("t5.addr", imem_addr, 32'hFFFF_FFFE);
    step();
    for (int k = 0; k < 6; k++) begin
      logic [31:0] ep;
      ep = 32'hFFFF_FFFE + k;
      #1;
      chk($sformatf("t5.valid%0d", k), {31'd0, out_valid}, 32'd1);
      chk($sformatf("t5.pc%0d", k), out_pc, ep);
      chk($sformatf("t5.instr%0d", k), out_instr, A + ep);
      step();
    end

    // test 6: reset with count=3 and a concurrent redirect
    drive(0, 0, 0, 0);
    step();
    step();
    #1;
    chk("t6.occ3", {29'd0, occupancy}, 32'd3);
    drive(1, 1, 32'h55, 0);
    step();
    drive(0, 0, 0, 0);
    #1;
    chk_all("t6.reset", 0, 0, 0, 0, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Upstream fetch stage for the 256x32 instruction ROM. Holds the program counter and drives the ROM word address. Captures the combinational read data into a small in-order instruction queue, together with its PC. Delivers {instr, pc} pairs to decode over a valid/ready handshake and supports branch/jump redirect with a full flush.

Parameters:
DEPTH, 4, instruction queue depth in entries; power of two, minimum 2
RESET_PC, 32'h0000_0000, PC value loaded by reset; a word index

Ports:
clk  input  1  system clock; all state updates on the rising edge
rst  input  1  synchronous reset, active-high
imem_addr  output  32  ROM word address; equals the PC register directly, no logic in the path
imem_rdata  input  32  ROM read data for imem_addr; valid in the same cycle (combinational ROM)
redirect_valid  input  1  flush the queue and load a new PC this cycle
redirect_pc  input  32  target word address, sampled when redirect_valid=1
out_valid  output  1  queue head holds an instruction and no redirect is active
out_ready  input  1  decode accepts the head this cycle
out_instr  output  32  instruction at queue head; 0 when the queue is empty
out_pc  output  32  word address of out_instr; 0 when the queue is empty
occupancy  output  $clog2(DEPTH)+1  number of valid queue entries

Behaviour:
- State:
  - pc register (32b)
  - circular queue of DEPTH entries {pc, instr}
  - head and tail pointers, each $clog2(DEPTH) bits, wrapping modulo DEPTH
  - count register
- Reset (rst=1 at an edge): pc=RESET_PC, head=tail=0, count=0. Consequently out_valid=0, out_instr=0, out_pc=0, occupancy=0, imem_addr=RESET_PC. Reset has priority over every other input, including redirect_valid.
- Combinational outputs:
  - out_valid = (count!=0) && !redirect_valid
  - pop = out_valid && out_ready
- Fetch condition: fetch = !redirect_valid && (count<DEPTH || pop).
- On fetch at an edge:
  - queue[tail] <= {pc, imem_rdata}
  - tail <= tail+1
  - pc <= pc+1 (32-bit modulo arithmetic; 32'hFFFF_FFFF wraps to 0)
- On pop at an edge: head <= head+1.
- Count update:
  - count += fetch - pop
  - a simultaneous fetch and pop when full keeps count=DEPTH; the freed slot is refilled in the same cycle
  - a simultaneous fetch and pop when count=1 keeps count=1
- No stall input. With out_ready held high, one instruction is delivered per cycle in steady state.
- Latency: a PC value presented on imem_addr in cycle N appears at the queue head no earlier than cycle N+1. The first out_valid after reset release occurs in the cycle after the first fetch.
- Redirect (redirect_valid=1, rst=0):
  - head=tail=0, count=0, pc<=redirect_pc
  - no fetch and no pop that cycle; out_valid=0
  - the next cycle fetches from redirect_pc; out_valid returns one cycle after that
  - a redirect held for multiple cycles reloads pc each cycle and keeps the queue empty
- Full: when count=DEPTH and out_ready=0, pc holds and imem_addr is stable. Queue contents are never overwritten.
- Empty: out_valid=0 regardless of out_ready. out_ready while empty has no effect.
- Order: entries leave in exactly the order fetched. out_pc of consecutive pops increments by 1 unless a redirect intervenes.
- The block is fully synchronous; no path exists from imem_rdata to any output other than through the queue registers.

Test Plan:
1. Reset with RESET_PC=0 and ROM word k = 32'hA000_0000+k, out_ready=1 from release -> first out_valid one cycle after release with out_pc=0, out_instr=A000_0000. Then one instruction per cycle with pc 1,2,3...
2. Backpressure: out_ready=0 for 10 cycles after reset -> occupancy climbs 1..4 and saturates at 4, imem_addr holds at 4, out_pc stays 0. Release out_ready -> pcs 0,1,2,3,4,... delivered with no gaps or duplicates.
3. Redirect with queue full (pcs 0..3 queued) and redirect_pc=32'h40 -> out_valid=0 in that cycle, occupancy=0 next cycle, imem_addr=40. Next delivered out_pc=40 with out_instr=ROM[40]; pcs 0..3 never appear.
4. Simultaneous redirect and out_ready=1 with count=2 -> no pop counted, queue flushed. Redirect held 3 cycles with targets 10, 20, 30 -> only 30 is fetched afterwards.
5. Wrap: redirect_pc=32'hFFFF_FFFE, out_ready=1 -> out_pc sequence FFFF_FFFE, FFFF_FFFF, 0000_0000, 0000_0001. Queue pointers wrap past DEPTH with correct order.
6. Reset asserted mid-stream with count=3 and redirect_valid=1 -> after the edge occupancy=0, out_valid=0, imem_addr=RESET_PC. Redirect ignored.
